// File: rtl/alu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct values and the decoded-instruction bundle.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic {Src2Rt, Src2Imm} src2_sel_e;
    typedef enum logic [1:0] {RdNone, RdRd, RdRt} rd_sel_e;

    typedef struct packed {
        logic [2:0] ctrl;
        src2_sel_e  src2_sel;
        logic       ext_sign;
        rd_sel_e    rd_sel;
        logic       illegal;
    } decoded_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (decode/regfile) and downstream (execute) handshake bundle for the issue stage.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [4:0]        rd_addr;
    logic              illegal;

    modport slave (
        input  in_valid, instr, rs_data, rt_data, flush, out_ready,
        output in_ready, out_valid, alu_ctrl, alu_src1, alu_src2, rd_addr, illegal
    );

    modport master (
        output in_valid, instr, rs_data, rt_data, flush, out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_src1, alu_src2, rd_addr, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder producing the ALU control bundle.
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output decoded_t   dec_o
);

    always_comb begin
        dec_o = '{ctrl: ALU_ADD, src2_sel: Src2Rt, ext_sign: 1'b0, rd_sel: RdNone, illegal: 1'b0};
        case (opcode_i)
            OP_RTYPE: begin
                dec_o.rd_sel = RdRd;
                case (funct_i)
                    F_ADD, F_ADDU: dec_o.ctrl = ALU_ADD;
                    F_SUB, F_SUBU: dec_o.ctrl = ALU_SUB;
                    F_AND:         dec_o.ctrl = ALU_AND;
                    F_OR:          dec_o.ctrl = ALU_OR;
                    F_SLT:         dec_o.ctrl = ALU_SLT;
                    default: begin
                        dec_o.rd_sel  = RdNone;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                dec_o.src2_sel = Src2Imm;
                dec_o.ext_sign = 1'b1;
                dec_o.rd_sel   = RdRt;
            end
            OP_SLTI: begin
                dec_o.ctrl     = ALU_SLT;
                dec_o.src2_sel = Src2Imm;
                dec_o.ext_sign = 1'b1;
                dec_o.rd_sel   = RdRt;
            end
            OP_SW: begin
                dec_o.src2_sel = Src2Imm;
                dec_o.ext_sign = 1'b1;
            end
            OP_ANDI: begin
                dec_o.ctrl     = ALU_AND;
                dec_o.src2_sel = Src2Imm;
                dec_o.rd_sel   = RdRt;
            end
            OP_ORI: begin
                dec_o.ctrl     = ALU_OR;
                dec_o.src2_sel = Src2Imm;
                dec_o.rd_sel   = RdRt;
            end
            // Branches compare rs and rt; execute looks at the zero flag.
            OP_BEQ, OP_BNE: dec_o.ctrl = ALU_SUB;
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand muxing and a one-entry valid/ready pipeline register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  io
);

    decoded_t          dec;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] src1_d, src2_d;
    logic [4:0]        rd_d;
    logic              capture;
    logic              unused_rs_field;

    logic              valid_q;
    logic [2:0]        ctrl_q;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [4:0]        rd_q;
    logic              illegal_q;

    // rs is already resolved to rs_data by the register file.
    assign unused_rs_field = ^io.instr[25:21];

    alu_decode u_decode (
        .opcode_i (io.instr[31:26]),
        .funct_i  (io.instr[5:0]),
        .dec_o    (dec)
    );

    always_comb begin
        imm_ext = dec.ext_sign ? {{(DATA_W-16){io.instr[15]}}, io.instr[15:0]}
                               : {{(DATA_W-16){1'b0}}, io.instr[15:0]};
        src1_d  = io.rs_data;
        src2_d  = (dec.src2_sel == Src2Imm) ? imm_ext : io.rt_data;
        if (dec.illegal) begin
            src1_d = '0;
            src2_d = '0;
        end
        case (dec.rd_sel)
            RdRd:    rd_d = io.instr[15:11];
            RdRt:    rd_d = io.instr[20:16];
            default: rd_d = 5'd0;
        endcase
    end

    assign io.in_ready = !valid_q || io.out_ready;
    assign capture     = io.in_valid && io.in_ready && !io.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= ALU_AND;
            src1_q    <= '0;
            src2_q    <= '0;
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else if (io.flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            ctrl_q    <= dec.ctrl;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            rd_q      <= rd_d;
            illegal_q <= dec.illegal;
        end else if (valid_q && io.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign io.out_valid = valid_q;
    assign io.alu_ctrl  = ctrl_q;
    assign io.alu_src1  = src1_q;
    assign io.alu_src2  = src2_q;
    assign io.rd_addr   = rd_q;
    assign io.illegal   = illegal_q;

endmodule
